// File: rtl/demux_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// demux_frame_sequencer_if
// Groups the serial command input, the decoded demux drive and the status
// signals of the frame sequencer.
//   master : frame source / controller (drives ser_in, ser_valid, err_clr)
//   slave  : the sequencer (drives everything else)
// Signals:
//   ser_in, ser_valid, ser_ready : bit-serial handshake, beat on valid & ready
//   in, s0, s1, s2               : data bit and select lines to the 1:8 demux
//   out_strobe                   : one-cycle pulse when the demux drive updates
//   busy                         : frame in progress or hold window active
//   frame_err, err_clr           : sticky bad-stop-bit flag and its clear
//   frame_cnt                    : good-frame counter, wraps
// -----------------------------------------------------------------------------
interface demux_frame_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             ser_ready;
    logic             in;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             out_strobe;
    logic             busy;
    logic             frame_err;
    logic             err_clr;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output ser_in, ser_valid, err_clr,
        input  ser_ready, in, s0, s1, s2, out_strobe, busy, frame_err, frame_cnt
    );

    modport slave (
        input  ser_in, ser_valid, err_clr,
        output ser_ready, in, s0, s1, s2, out_strobe, busy, frame_err, frame_cnt
    );
endinterface

// File: rtl/demux_frame_sequencer.sv
// -----------------------------------------------------------------------------
// demux_frame_sequencer
// Receives a bit-serial command frame (start=1, s2, s1, s0, data, stop=0) and
// presents the decoded select lines and data bit to a 1:8 demux as a single
// registered update. The data bit is held for HOLD_CYCLES cycles, then
// returned to 0; the select lines persist until the next good frame.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : demux_frame_sequencer_if.slave (serial handshake, demux drive,
//           status, error clear, frame counter)
// -----------------------------------------------------------------------------
module demux_frame_sequencer #(
    parameter int HOLD_CYCLES = 5,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    demux_frame_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        STOP,
        HOLD
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_bit_idx;
    logic [2:0]       r_sel_sh;
    logic             r_data_sh;
    logic [7:0]       r_hold_cnt;
    logic [2:0]       r_sel;
    logic             r_in;
    logic             r_strobe;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_ser_ready;
    logic             w_accept;
    logic             w_good_stop;
    logic             w_bad_stop;

    // The serial port is deaf for the whole hold window, including its last
    // cycle; a start bit offered then is taken one cycle later in IDLE.
    assign w_ser_ready = (r_state != HOLD);
    assign w_accept    = bus.ser_valid & w_ser_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        w_good_stop  = 1'b0;
        w_bad_stop   = 1'b0;
        case (r_state)
            IDLE: begin
                // A 0 on an idle line is just line-idle and is discarded.
                if (w_accept && bus.ser_in) w_next_state = ADDR;
            end
            ADDR: begin
                if (w_accept && (r_bit_idx == 2'd2)) w_next_state = DATA;
            end
            DATA: begin
                if (w_accept) w_next_state = STOP;
            end
            STOP: begin
                if (w_accept) begin
                    if (bus.ser_in) begin
                        w_bad_stop   = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_good_stop  = 1'b1;
                        w_next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (r_hold_cnt == 8'd0) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx   <= 2'd0;
            r_sel_sh    <= 3'd0;
            r_data_sh   <= 1'b0;
            r_hold_cnt  <= 8'd0;
            r_sel       <= 3'd0;
            r_in        <= 1'b0;
            r_strobe    <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_strobe    <= w_good_stop;
            // A new error on the same edge as a clear keeps the flag set.
            r_frame_err <= w_bad_stop | (r_frame_err & ~bus.err_clr);

            if (w_accept) begin
                case (r_state)
                    IDLE: r_bit_idx <= 2'd0;
                    ADDR: begin
                        r_sel_sh  <= {r_sel_sh[1:0], bus.ser_in};
                        r_bit_idx <= r_bit_idx + 2'd1;
                    end
                    DATA: r_data_sh <= bus.ser_in;
                    default: ;
                endcase
            end

            // The whole demux drive changes on the stop-bit edge only, so a
            // partial frame is never visible downstream.
            if (w_good_stop) begin
                r_sel       <= r_sel_sh;
                r_in        <= r_data_sh;
                r_hold_cnt  <= HOLD_LOAD;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end else if (r_state == HOLD) begin
                if (r_hold_cnt == 8'd0) begin
                    r_in <= 1'b0;
                end else begin
                    r_hold_cnt <= r_hold_cnt - 8'd1;
                end
            end
        end
    end

    assign bus.ser_ready  = w_ser_ready;
    assign bus.busy       = (r_state != IDLE);
    assign bus.in         = r_in;
    assign bus.s0         = r_sel[0];
    assign bus.s1         = r_sel[1];
    assign bus.s2         = r_sel[2];
    assign bus.out_strobe = r_strobe;
    assign bus.frame_err  = r_frame_err;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_demux_frame_sequencer
// Directed bench for demux_frame_sequencer. Instance dut1 (HOLD_CYCLES=5,
// CNT_W=8) takes a table of frames plus hand-written corner sequences;
// instance dut2 (CNT_W=2) mirrors dut1's serial input when enabled and is
// used for the counter-wrap sequence.
// -----------------------------------------------------------------------------
module tb_demux_frame_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en2   = 1'b0;

    always #5 clk = ~clk;

    demux_frame_sequencer_if #(.CNT_W(8)) bus1 ();
    demux_frame_sequencer_if #(.CNT_W(2)) bus2 ();

    assign bus2.ser_in    = bus1.ser_in;
    assign bus2.ser_valid = bus1.ser_valid & en2;
    assign bus2.err_clr   = 1'b0;

    demux_frame_sequencer #(.HOLD_CYCLES(5), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    demux_frame_sequencer #(.HOLD_CYCLES(5), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] sel;
        logic       data;
        logic       stop;
        int         gap;
        logic [2:0] exp_s;
        logic       exp_in;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_beat(input logic b);
        bus1.ser_valid = 1'b1;
        bus1.ser_in    = b;
        @(negedge clk);
        bus1.ser_valid = 1'b0;
        bus1.ser_in    = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] sel, input logic data, input logic stop, input int gap);
        logic [5:0] bits;
        bits = {1'b1, sel, data, stop};
        for (int i = 5; i >= 0; i--) begin
            send_beat(bits[i]);
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    check("busy_in_gap", 32'(bus1.busy), 32'd1);
                    @(negedge clk);
                end
            end
        end
    endtask

    // Called on the cycle after the stop beat; walks to IDLE counting cycles.
    task automatic wait_hold(input logic good, input logic data);
        int  nb;
        int  ni;
        int  ns;
        bit  done;
        nb = 0; ni = 0; ns = 0; done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus1.busy) begin
                done = 1'b1;
                break;
            end
            nb += 1;
            ni += int'(bus1.in);
            ns += int'(bus1.out_strobe);
            @(negedge clk);
        end
        check("hold_timeout", 32'(done), 32'd1);
        check("hold_busy_cycles", 32'(nb), good ? 32'd5 : 32'd0);
        check("hold_in_cycles", 32'(ni), (good && data) ? 32'd5 : 32'd0);
        check("strobe_pulses", 32'(ns), good ? 32'd1 : 32'd0);
        check("in_after_hold", 32'(bus1.in), 32'd0);
    endtask

    task automatic check_decode(input string tag, input logic [2:0] s, input logic d, input logic [7:0] cnt);
        check({tag, "_sel"}, 32'({bus1.s2, bus1.s1, bus1.s0}), 32'(s));
        check({tag, "_in"},  32'(bus1.in), 32'(d));
        check({tag, "_cnt"}, 32'(bus1.frame_cnt), 32'(cnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},    32'({bus1.s2, bus1.s1, bus1.s0}), 32'd0);
        check({tag, "_in"},     32'(bus1.in), 32'd0);
        check({tag, "_strobe"}, 32'(bus1.out_strobe), 32'd0);
        check({tag, "_busy"},   32'(bus1.busy), 32'd0);
        check({tag, "_err"},    32'(bus1.frame_err), 32'd0);
        check({tag, "_cnt"},    32'(bus1.frame_cnt), 32'd0);
        check({tag, "_ready"},  32'(bus1.ser_ready), 32'd1);
    endtask

    initial begin
        int         nlow;
        logic [1:0] wrap_exp[5];

        bus1.ser_in    = 1'b0;
        bus1.ser_valid = 1'b0;
        bus1.err_clr   = 1'b0;

        vecs[0] = '{3'b010, 1'b1, 1'b0, 0, 3'b010, 1'b1, 1'b0, 8'd1};
        vecs[1] = '{3'b101, 1'b0, 1'b0, 3, 3'b101, 1'b0, 1'b0, 8'd2};
        vecs[2] = '{3'b110, 1'b1, 1'b1, 0, 3'b101, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{3'b011, 1'b1, 1'b0, 1, 3'b011, 1'b1, 1'b1, 8'd3};
        vecs[4] = '{3'b111, 1'b1, 1'b0, 0, 3'b111, 1'b1, 1'b1, 8'd4};
        vecs[5] = '{3'b000, 1'b0, 1'b0, 2, 3'b000, 1'b0, 1'b1, 8'd5};

        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus1.ser_ready), 32'd1);

        // Table of frames
        foreach (vecs[k]) begin
            send_frame(vecs[k].sel, vecs[k].data, vecs[k].stop, vecs[k].gap);
            check_decode($sformatf("vec%0d", k), vecs[k].exp_s, vecs[k].exp_in, vecs[k].exp_cnt);
            check($sformatf("vec%0d_err", k), 32'(bus1.frame_err), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_strobe", k), 32'(bus1.out_strobe), 32'(!vecs[k].stop));
            wait_hold(!vecs[k].stop, vecs[k].data);
        end

        // err_clr drops the sticky flag on the next edge
        bus1.err_clr = 1'b1;
        @(negedge clk);
        bus1.err_clr = 1'b0;
        check("err_cleared", 32'(bus1.frame_err), 32'd0);

        // Error and clear on the same edge: set wins
        bus1.err_clr = 1'b1;
        send_frame(3'b001, 1'b1, 1'b1, 0);
        bus1.err_clr = 1'b0;
        check("err_set_wins", 32'(bus1.frame_err), 32'd1);
        check_decode("bad_keeps", 3'b000, 1'b0, 8'd5);
        @(negedge clk);
        check("err_sticky", 32'(bus1.frame_err), 32'd1);
        bus1.err_clr = 1'b1;
        @(negedge clk);
        bus1.err_clr = 1'b0;
        check("err_cleared2", 32'(bus1.frame_err), 32'd0);

        // Start bit offered during HOLD is refused until IDLE
        send_frame(3'b110, 1'b1, 1'b0, 0);
        check_decode("pre_hold", 3'b110, 1'b1, 8'd6);
        bus1.ser_valid = 1'b1;
        bus1.ser_in    = 1'b1;
        nlow = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus1.ser_ready) break;
            nlow++;
            @(negedge clk);
        end
        check("ready_low_cycles", 32'(nlow), 32'd5);
        check("ready_high_idle", 32'(bus1.ser_ready), 32'd1);
        check("busy_idle", 32'(bus1.busy), 32'd0);
        send_frame(3'b001, 1'b0, 1'b0, 0);
        check_decode("after_hold", 3'b001, 1'b0, 8'd7);
        check("after_hold_strobe", 32'(bus1.out_strobe), 32'd1);
        wait_hold(1'b1, 1'b0);

        // Asynchronous reset partway through the address bits
        send_beat(1'b1);
        send_beat(1'b1);
        send_beat(1'b0);
        check("addr_busy", 32'(bus1.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_addr");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(3'b100, 1'b1, 1'b0, 0);
        check_decode("post_rst_addr", 3'b100, 1'b1, 8'd1);
        wait_hold(1'b1, 1'b1);

        // Asynchronous reset during HOLD
        send_frame(3'b011, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("hold_in_before_rst", 32'(bus1.in), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(3'b101, 1'b1, 1'b0, 0);
        check_decode("post_rst_hold", 3'b101, 1'b1, 8'd1);
        wait_hold(1'b1, 1'b1);

        // Counter wrap on the 2-bit instance
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_frame(3'(i), 1'b1, 1'b0, 0);
            check($sformatf("wrap_cnt%0d", i), 32'(bus2.frame_cnt), 32'(wrap_exp[i]));
            check($sformatf("wide_cnt%0d", i), 32'(bus1.frame_cnt), 32'(i + 1));
            wait_hold(1'b1, 1'b1);
        end
        en2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
